// File: rtl/inert_pkg.sv
// Shared types and helpers for the multi-axis inertial integrator.
// Used by the top-level FSM and the per-axis datapath.
package inert_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CAL,
        RUN
    } state_t;

    localparam int RATE_W_DEF   = 16;
    localparam int CAL_LOG2_DEF = 11;
    localparam int SUM_W        = RATE_W_DEF + CAL_LOG2_DEF;
    localparam int BUS_W        = 256;

    function automatic int sum_w(input int rate_w, input int cal_log2);
        return rate_w + cal_log2;
    endfunction

    // Extract field idx of width w from a packed bus and sign-extend to 32 bits.
    function automatic logic signed [31:0] sext_slice(
        input logic [BUS_W-1:0] bus,
        input int               idx,
        input int               w
    );
        logic [BUS_W-1:0] sh;
        logic [31:0]      raw;
        sh  = bus >> (idx * w);
        raw = sh[31:0];
        return $signed(raw << (32 - w)) >>> (32 - w);
    endfunction

endpackage

// File: rtl/inert_axis.sv
// One gyro axis: calibration sum, offset, dead-band and wrapping
// heading accumulator, driven by strobes from the shared FSM.
module inert_axis
    import inert_pkg::*;
#(
    parameter int          RATE_W   = 16,
    parameter int          CAL_LOG2 = 11,
    parameter int          ACC_W    = 27,
    parameter int          HEAD_W   = 12,
    parameter int unsigned DEADBAND = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_sum_i,
    input  logic               add_sum_i,
    input  logic               latch_off_i,
    input  logic               clr_acc_i,
    input  logic               integ_i,
    input  logic signed [31:0] rate_i,
    output logic [HEAD_W-1:0]  heading_o
);

    localparam int SW = sum_w(RATE_W, CAL_LOG2);
    localparam int CW = RATE_W + 1;

    logic signed [SW-1:0]     sum_q, sum_d, sum_n;
    logic signed [RATE_W-1:0] off_q, off_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [CW-1:0]     corr, corr_db;
    logic [CW-1:0]            mag;
    logic                     dead;

    assign sum_n = sum_q + SW'(rate_i);
    assign off_d = RATE_W'(sum_n >>> CAL_LOG2);

    // CW bits hold rate - offset for any pair of RATE_W operands.
    assign corr    = CW'(rate_i) - CW'(off_q);
    assign mag     = corr[CW-1] ? -corr : corr;
    assign dead    = (DEADBAND > 0) && (mag < CW'(DEADBAND));
    assign corr_db = dead ? '0 : corr;
    assign acc_d   = acc_q + ACC_W'(corr_db);

    always_comb begin
        sum_d = sum_q;
        if (clr_sum_i) begin
            sum_d = '0;
        end else if (add_sum_i) begin
            sum_d = sum_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
            off_q <= '0;
            acc_q <= '0;
        end else begin
            sum_q <= sum_d;
            if (latch_off_i) begin
                off_q <= off_d;
            end
            if (clr_acc_i) begin
                acc_q <= '0;
            end else if (integ_i) begin
                acc_q <= acc_d;
            end
        end
    end

    assign heading_o = acc_q[ACC_W-1 -: HEAD_W];

endmodule

// File: rtl/inert_integ_multi.sv
// Multi-axis gyro integrator: calibration/run FSM plus NUM_CH
// per-axis datapaths sharing its control strobes.
module inert_integ_multi
    import inert_pkg::*;
#(
    parameter int          NUM_CH   = 3,
    parameter int          RATE_W   = 16,
    parameter int          CAL_LOG2 = 11,
    parameter int          ACC_W    = 27,
    parameter int          HEAD_W   = 12,
    parameter int unsigned DEADBAND = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     strt_cal,
    input  logic                     moving,
    input  logic                     vld,
    input  logic [NUM_CH*RATE_W-1:0] rate,
    output logic [NUM_CH*HEAD_W-1:0] heading,
    output logic                     rdy,
    output logic                     cal_done,
    output logic                     cal_busy
);

    state_t              state_q, state_d;
    logic [CAL_LOG2-1:0] cnt_q, cnt_d;
    logic                rdy_q, rdy_d;
    logic                done_q, done_d;
    logic                clr_sum, add_sum, latch_off, clr_acc, integ;
    logic [BUS_W-1:0]    rate_pad;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rdy_d     = 1'b0;
        done_d    = 1'b0;
        clr_sum   = 1'b0;
        add_sum   = 1'b0;
        latch_off = 1'b0;
        clr_acc   = 1'b0;
        integ     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (strt_cal) begin
                    state_d = CAL;
                    cnt_d   = '0;
                    clr_sum = 1'b1;
                end
            end
            CAL: begin
                // A restart outranks a coincident sample, which is dropped.
                if (strt_cal) begin
                    cnt_d   = '0;
                    clr_sum = 1'b1;
                end else if (vld) begin
                    if (&cnt_q) begin
                        latch_off = 1'b1;
                        clr_acc   = 1'b1;
                        clr_sum   = 1'b1;
                        done_d    = 1'b1;
                        cnt_d     = '0;
                        state_d   = RUN;
                    end else begin
                        add_sum = 1'b1;
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
            end
            RUN: begin
                if (strt_cal) begin
                    state_d = CAL;
                    cnt_d   = '0;
                    clr_sum = 1'b1;
                end else if (vld) begin
                    integ = moving;
                    rdy_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdy_q   <= rdy_d;
            done_q  <= done_d;
        end
    end

    assign rdy      = rdy_q;
    assign cal_done = done_q;
    assign cal_busy = (state_q == CAL);
    assign rate_pad = BUS_W'(rate);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_axis
        logic signed [31:0] r32;
        assign r32 = sext_slice(rate_pad, g, RATE_W);

        inert_axis #(
            .RATE_W   (RATE_W),
            .CAL_LOG2 (CAL_LOG2),
            .ACC_W    (ACC_W),
            .HEAD_W   (HEAD_W),
            .DEADBAND (DEADBAND)
        ) u_axis (
            .clk         (clk),
            .rst         (rst),
            .clr_sum_i   (clr_sum),
            .add_sum_i   (add_sum),
            .latch_off_i (latch_off),
            .clr_acc_i   (clr_acc),
            .integ_i     (integ),
            .rate_i      (r32),
            .heading_o   (heading[g*HEAD_W +: HEAD_W])
        );
    end

endmodule

// File: tb/tb_inert_integ_multi.sv
// Directed bench for inert_integ_multi: two instances, DEADBAND 0 and 4,
// driven by the same stimulus.
module tb_inert_integ_multi;

    logic        clk = 1'b0;
    logic        rst;
    logic        strt_cal;
    logic        moving;
    logic        vld;
    logic [31:0] rate;
    logic [23:0] head_a, head_b;
    logic        rdy_a, rdy_b;
    logic        done_a, done_b;
    logic        busy_a, busy_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    inert_integ_multi #(
        .NUM_CH(2), .RATE_W(16), .CAL_LOG2(2),
        .ACC_W(16), .HEAD_W(12), .DEADBAND(0)
    ) dut_a (
        .clk(clk), .rst(rst), .strt_cal(strt_cal), .moving(moving),
        .vld(vld), .rate(rate), .heading(head_a), .rdy(rdy_a),
        .cal_done(done_a), .cal_busy(busy_a)
    );

    inert_integ_multi #(
        .NUM_CH(2), .RATE_W(16), .CAL_LOG2(2),
        .ACC_W(16), .HEAD_W(12), .DEADBAND(4)
    ) dut_b (
        .clk(clk), .rst(rst), .strt_cal(strt_cal), .moving(moving),
        .vld(vld), .rate(rate), .heading(head_b), .rdy(rdy_b),
        .cal_done(done_b), .cal_busy(busy_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int r0, input int r1);
        logic [15:0] a, b;
        a    = 16'(r0);
        b    = 16'(r1);
        rate = {b, a};
        vld  = 1'b1;
        cyc();
        vld  = 1'b0;
    endtask

    task automatic pulse_cal();
        strt_cal = 1'b1;
        cyc();
        strt_cal = 1'b0;
    endtask

    initial begin
        rst = 1'b1; strt_cal = 1'b0; moving = 1'b0; vld = 1'b0; rate = '0;
        cyc(); cyc();
        rst = 1'b0;
        cyc();
        chk("reset_head", {8'h0, head_a}, 32'h0);
        chk("reset_flags", {rdy_a, done_a, busy_a}, 3'b000);

        // Calibration: offsets 13 and floor(-7.75) = -8.
        pulse_cal();
        chk("cal_busy", busy_a, 1'b1);
        send(10, -8); send(12, -8); send(14, -8);
        chk("cal_no_done", {done_a, busy_a}, 2'b01);
        send(16, -7);
        chk("cal_done", {done_a, busy_a, rdy_a}, 3'b100);
        chk("cal_head", head_a, 24'h0);
        cyc();
        chk("cal_done_1cyc", done_a, 1'b0);

        // Dead-band: A integrates 12,3,3 -> 18; B drops the 3s -> 12.
        moving = 1'b1;
        send(25, -8); send(16, -8); send(16, -8);
        chk("db_a_small", head_a[11:0], 12'h001);
        chk("db_b_small", head_b[11:0], 12'h000);
        send(17, -8);
        chk("db_a_four", head_a[11:0], 12'h001);
        chk("db_b_four", head_b[11:0], 12'h001);

        // Recalibrate from RUN; heading holds during CAL.
        pulse_cal();
        send(10, -8);
        chk("hold_in_cal", head_a, 24'h000001);
        chk("no_rdy_in_cal", rdy_a, 1'b0);
        send(12, -8); send(14, -8); send(16, -7);
        chk("recal_done", done_a, 1'b1);
        chk("recal_clear", head_a, 24'h0);

        // Integration: corr +1024 / -2048, four samples.
        for (int i = 0; i < 4; i++) begin
            send(13 + 1024, -8 - 2048);
            chk("integ_rdy", {rdy_a, done_a}, 2'b10);
        end
        chk("integ_h0", head_a[11:0], 12'd256);
        chk("integ_h1", head_a[23:12], 12'hE00);
        cyc();
        chk("rdy_drop", rdy_a, 1'b0);

        // Moving gate.
        moving = 1'b0;
        send(13 + 1024, -8 - 2048);
        chk("gate_rdy", rdy_a, 1'b1);
        chk("gate_head", head_a, {12'hE00, 12'd256});
        moving = 1'b1;

        // Wrap: 28 more -> 0x8000, 32 more -> 0x10000 wraps to 0.
        for (int i = 0; i < 28; i++) send(13 + 1024, -8);
        chk("wrap_mid", head_a[11:0], 12'h800);
        for (int i = 0; i < 32; i++) send(13 + 1024, -8);
        chk("wrap_h0", head_a[11:0], 12'h000);
        chk("wrap_h1", head_a[23:12], 12'hE00);

        // Collision: strt_cal with vld drops the sample and restarts.
        pulse_cal();
        send(1000, 1000); send(1000, 1000);
        strt_cal = 1'b1; vld = 1'b1; rate = {16'd500, 16'd500};
        cyc();
        strt_cal = 1'b0; vld = 1'b0;
        chk("coll_busy", {busy_a, done_a}, 2'b10);
        send(20, 0); send(20, 0); send(20, 0);
        chk("coll_not_yet", done_a, 1'b0);
        send(24, -1);
        chk("coll_done", done_a, 1'b1);
        // Offsets 21 and -1; corr +16 / -16.
        send(37, -17);
        chk("coll_off", head_a, {12'hFFF, 12'h001});

        // Reset mid-RUN.
        rst = 1'b1; cyc(); rst = 1'b0;
        chk("rst_run_head", head_a, 24'h0);
        chk("rst_run_flags", {rdy_a, done_a, busy_a}, 3'b000);
        send(100, 100);
        chk("idle_ignore", {rdy_a, busy_a, done_a}, 3'b000);
        chk("idle_head", head_a, 24'h0);

        // Reset mid-CAL.
        pulse_cal();
        send(5, 5); send(5, 5);
        rst = 1'b1; cyc(); rst = 1'b0;
        chk("rst_cal_busy", busy_a, 1'b0);
        send(5, 5); send(5, 5); send(5, 5); send(5, 5);
        chk("rst_cal_ignore", {done_a, busy_a, rdy_a}, 3'b000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
